syn_cortex_lb_bridge: RTL

Byte-stream to local-bus master bridge that drives the 16-bit-address, 32-bit-data cortex local bus (ACORTEX/VCORTEX decode downstream).
Accepts framed read/write commands from an 8-bit host byte stream (UART/host RX side) and issues single-cycle rd_en/wr_en strobes.
Waits for rd_valid/wr_valid with a timeout and returns framed response bytes on an 8-bit TX stream.
Only one transaction is outstanding at any time.

---
 rtl/syn_cortex_lb_bridge.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/syn_cortex_lb_bridge.sv
`timescale 1ns/1ps
// syn_cortex_lb_bridge
// Byte-stream to cortex local-bus master bridge. Host command frames arrive on
// an 8-bit RX stream; each frame becomes one single-cycle rd/wr strobe on the
// local bus. The bridge then waits (with timeout) for the matching valid and
// returns a framed response on an 8-bit TX stream. Only one transaction is
// in flight at a time.
//
// Frames (MSB first):  read  52 A1 A0            -> 4B D3 D2 D1 D0 | 54
//                      write 57 A1 A0 D3 D2 D1 D0 -> 4B | 54
//                      any other leading byte     -> 3F
// Optional build macro SYN_CORTEX_LB_BRIDGE_CSUM_EN: every command frame ends
// with an XOR checksum byte (mismatch -> 43, no strobe), and every response
// ends with the XOR of its bytes.
//
// Ports:
//   clk_ir, rst_sync_l              clock, async active-low reset
//   rx_byte_valid/rx_byte/rx_byte_rdy  command byte stream in
//   tx_byte_valid/tx_byte/tx_byte_rdy  response byte stream out
//   lb_rd_en, lb_wr_en              1-cycle local bus strobes
//   lb_addr, lb_wr_data             address / write data, held through WAIT
//   lb_rd_valid, lb_wr_valid, lb_rd_data  local bus completion
//   busy                            high whenever not IDLE
module syn_cortex_lb_bridge #(
  parameter int P_LB_DWIDTH = 32,
  parameter int P_LB_AWIDTH = 16,
  parameter int P_TIMEOUT   = 255,
  parameter int P_TO_WIDTH  = 8
) (
  input  logic                   clk_ir,
  input  logic                   rst_sync_l,
  input  logic                   rx_byte_valid,
  input  logic [7:0]             rx_byte,
  output logic                   rx_byte_rdy,
  output logic                   tx_byte_valid,
  output logic [7:0]             tx_byte,
  input  logic                   tx_byte_rdy,
  output logic                   lb_rd_en,
  output logic                   lb_wr_en,
  output logic [P_LB_AWIDTH-1:0] lb_addr,
  output logic [P_LB_DWIDTH-1:0] lb_wr_data,
  input  logic                   lb_rd_valid,
  input  logic                   lb_wr_valid,
  input  logic [P_LB_DWIDTH-1:0] lb_rd_data,
  output logic                   busy
);

  localparam logic [7:0] C_RD  = 8'h52;
  localparam logic [7:0] C_WR  = 8'h57;
  localparam logic [7:0] C_OK  = 8'h4B;
  localparam logic [7:0] C_TO  = 8'h54;
  localparam logic [7:0] C_UNK = 8'h3F;
`ifdef SYN_CORTEX_LB_BRIDGE_CSUM_EN
  localparam logic [7:0] C_CS  = 8'h43;
`endif
  localparam logic [P_TO_WIDTH-1:0] LP_TO = P_TO_WIDTH'(P_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_RESP  = 3'd5
`ifdef SYN_CORTEX_LB_BRIDGE_CSUM_EN
    , S_CSUM = 3'd6
`endif
  } state_t;

  state_t                 r_state, w_next;
  logic                   r_live;     // holds rx_byte_rdy low during/just after reset
  logic                   r_op_wr;
  logic [1:0]             r_byte_cnt;
  logic [P_LB_AWIDTH-1:0] r_addr;
  logic [P_LB_DWIDTH-1:0] r_wdata;
  logic [P_LB_DWIDTH-1:0] r_rd_data;
  logic [P_TO_WIDTH-1:0]  r_to_cnt;
  logic [7:0]             r_code;
  logic                   r_rd_ok;    // response carries the 4 read-data bytes
  logic [2:0]             r_tx_idx;
`ifdef SYN_CORTEX_LB_BRIDGE_CSUM_EN
  logic [7:0]             r_rx_csum;
  logic [7:0]             w_tx_csum;
  logic                   w_cs_ok;
`endif

  logic                   w_rx_rdy, w_rx_fire, w_tx_fire, w_known, w_hit, w_to_done;
  logic [P_TO_WIDTH-1:0]  w_to_inc;
  logic [2:0]             w_tx_last;
  logic [7:0]             w_tx_byte;
  state_t                 w_after_data;

  assign w_rx_rdy  = r_live & ((r_state == S_IDLE) | (r_state == S_ADDR) | (r_state == S_WDATA)
`ifdef SYN_CORTEX_LB_BRIDGE_CSUM_EN
                     | (r_state == S_CSUM)
`endif
                     );
  assign rx_byte_rdy   = w_rx_rdy;
  assign tx_byte_valid = (r_state == S_RESP);
  assign busy          = (r_state != S_IDLE);
  assign lb_addr       = r_addr;
  assign lb_wr_data    = r_wdata;

  assign w_rx_fire = rx_byte_valid & w_rx_rdy;
  assign w_tx_fire = tx_byte_valid & tx_byte_rdy;
  assign w_known   = (rx_byte == C_RD) | (rx_byte == C_WR);
  assign w_hit     = r_op_wr ? lb_wr_valid : lb_rd_valid;
  assign w_to_inc  = r_to_cnt + 1'b1;
  // Timeout fires on the WAIT cycle whose increment reaches P_TIMEOUT, giving
  // exactly P_TIMEOUT WAIT cycles; w_hit is tested first so valid wins a tie.
  assign w_to_done = (w_to_inc == LP_TO);

`ifdef SYN_CORTEX_LB_BRIDGE_CSUM_EN
  assign w_cs_ok      = (rx_byte == r_rx_csum);
  assign w_after_data = S_CSUM;
  assign w_tx_last    = r_rd_ok ? 3'd5 : 3'd1;
  assign w_tx_csum    = r_rd_ok ? (r_code ^ r_rd_data[31:24] ^ r_rd_data[23:16]
                                         ^ r_rd_data[15:8]  ^ r_rd_data[7:0])
                                : r_code;
`else
  assign w_after_data = S_ISSUE;
  assign w_tx_last    = r_rd_ok ? 3'd4 : 3'd0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    lb_rd_en = 1'b0;
    lb_wr_en = 1'b0;
    case (r_state)
      S_IDLE:  if (w_rx_fire) w_next = w_known ? S_ADDR : S_RESP;
      S_ADDR:  if (w_rx_fire && r_byte_cnt == 2'd1) w_next = r_op_wr ? S_WDATA : w_after_data;
      S_WDATA: if (w_rx_fire && r_byte_cnt == 2'd3) w_next = w_after_data;
`ifdef SYN_CORTEX_LB_BRIDGE_CSUM_EN
      S_CSUM:  if (w_rx_fire) w_next = w_cs_ok ? S_ISSUE : S_RESP;
`endif
      S_ISSUE: begin
        lb_rd_en = ~r_op_wr;
        lb_wr_en = r_op_wr;
        w_next   = S_WAIT;
      end
      S_WAIT:  if (w_hit || w_to_done) w_next = S_RESP;
      S_RESP:  if (w_tx_fire && r_tx_idx == w_tx_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      r_live     <= 1'b0;
      r_op_wr    <= 1'b0;
      r_byte_cnt <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_data  <= '0;
      r_to_cnt   <= '0;
      r_code     <= '0;
      r_rd_ok    <= 1'b0;
      r_tx_idx   <= '0;
`ifdef SYN_CORTEX_LB_BRIDGE_CSUM_EN
      r_rx_csum  <= '0;
`endif
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: if (w_rx_fire) begin
          r_op_wr    <= (rx_byte == C_WR);
          r_byte_cnt <= '0;
          r_tx_idx   <= '0;
          r_rd_ok    <= 1'b0;
          if (!w_known) r_code <= C_UNK;
`ifdef SYN_CORTEX_LB_BRIDGE_CSUM_EN
          r_rx_csum  <= rx_byte;
`endif
        end
        S_ADDR: if (w_rx_fire) begin
          r_addr     <= {r_addr[P_LB_AWIDTH-9:0], rx_byte};
          r_byte_cnt <= (r_byte_cnt == 2'd1) ? 2'd0 : r_byte_cnt + 2'd1;
`ifdef SYN_CORTEX_LB_BRIDGE_CSUM_EN
          r_rx_csum  <= r_rx_csum ^ rx_byte;
`endif
        end
        S_WDATA: if (w_rx_fire) begin
          r_wdata    <= {r_wdata[P_LB_DWIDTH-9:0], rx_byte};
          r_byte_cnt <= r_byte_cnt + 2'd1;  // wraps 3 -> 0
`ifdef SYN_CORTEX_LB_BRIDGE_CSUM_EN
          r_rx_csum  <= r_rx_csum ^ rx_byte;
`endif
        end
`ifdef SYN_CORTEX_LB_BRIDGE_CSUM_EN
        S_CSUM: if (w_rx_fire && !w_cs_ok) r_code <= C_CS;
`endif
        S_ISSUE: r_to_cnt <= '0;
        S_WAIT: begin
          r_to_cnt <= w_to_inc;
          if (w_hit) begin
            r_code  <= C_OK;
            r_rd_ok <= ~r_op_wr;
            if (!r_op_wr) r_rd_data <= lb_rd_data;
          end else if (w_to_done) begin
            r_code <= C_TO;
          end
        end
        S_RESP: if (w_tx_fire) r_tx_idx <= r_tx_idx + 3'd1;
        default: ;
      endcase
    end
  end

  // ---------------- response byte mux ----------------
  always_comb begin
    w_tx_byte = r_code;
    case (r_tx_idx)
      3'd1:    w_tx_byte = r_rd_data[31:24];
      3'd2:    w_tx_byte = r_rd_data[23:16];
      3'd3:    w_tx_byte = r_rd_data[15:8];
      3'd4:    w_tx_byte = r_rd_data[7:0];
      default: w_tx_byte = r_code;
    endcase
`ifdef SYN_CORTEX_LB_BRIDGE_CSUM_EN
    if (r_tx_idx == w_tx_last) w_tx_byte = w_tx_csum;
`endif
  end

  assign tx_byte = (r_state == S_RESP) ? w_tx_byte : 8'h00;

endmodule
